// File: rtl/apb_stdin_if.sv
// APB bus bundle shared by the stdin block and its bus master.
// The Slave modport is the register-side view; Master drives the requests.
interface APB_BUS #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport Master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_stdin.sv
// Host-to-core character queues: one byte FIFO per (cluster, core), drained over APB.
// Define APB_STDIN_DROP_EN to drop (and count) bytes sent to a full queue instead of stalling the host.
module apb_stdin #(
    parameter int unsigned N_CLUSTERS = 1,
    parameter int unsigned N_CORES    = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [3:0] in_cl_i,
    input  logic [3:0] in_core_i,
    input  logic [7:0] in_data_i,
    APB_BUS.Slave      apb
);

    localparam int unsigned N_FIFOS = N_CLUSTERS * N_CORES;
    localparam int unsigned IDX_W   = (N_FIFOS > 1) ? $clog2(N_FIFOS) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [IDX_W-1:0] idx_t;

    ptr_t       wr_ptr [N_FIFOS];
    ptr_t       rd_ptr [N_FIFOS];
    cnt_t       count  [N_FIFOS];
    logic [7:0] mem    [N_FIFOS][FIFO_DEPTH];

    logic [N_FIFOS-1:0] full;
    logic [N_FIFOS-1:0] empty;

    always_comb begin
        for (int unsigned f = 0; f < N_FIFOS; f++) begin
            full[f]  = (count[f] == cnt_t'(FIFO_DEPTH));
            empty[f] = (count[f] == '0);
        end
    end

    // Host side: indices outside the configured array are accepted and silently dropped.
    logic in_hit;
    idx_t in_idx;
    logic push_fire;

    assign in_hit    = ({28'd0, in_cl_i} < N_CLUSTERS) && ({28'd0, in_core_i} < N_CORES);
    assign in_idx    = idx_t'({28'd0, in_cl_i} * N_CORES + {28'd0, in_core_i});
    assign push_fire = in_valid_i && in_hit && !full[in_idx];

`ifdef APB_STDIN_DROP_EN
    logic       drop_fire;
    logic [15:0] drop_cnt [N_FIFOS];

    assign in_ready_o = 1'b1;
    assign drop_fire  = in_valid_i && in_hit && full[in_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned f = 0; f < N_FIFOS; f++) drop_cnt[f] <= '0;
        end else if (drop_fire && (drop_cnt[in_idx] != 16'hFFFF)) begin
            drop_cnt[in_idx] <= drop_cnt[in_idx] + 16'd1;
        end
    end
`else
    assign in_ready_o = !in_hit || !full[in_idx];
`endif

    // APB side: cluster in paddr[10:7], core in paddr[6:3], paddr[2] selects STATUS.
    logic [3:0] rd_cl;
    logic [3:0] rd_core;
    logic       is_status;
    logic       rd_hit;
    idx_t       rd_idx;
    logic       access;
    logic       pop_fire;

    assign rd_cl     = apb.paddr[10:7];
    assign rd_core   = apb.paddr[6:3];
    assign is_status = apb.paddr[2];
    assign rd_hit    = ({28'd0, rd_cl} < N_CLUSTERS) && ({28'd0, rd_core} < N_CORES);
    assign rd_idx    = idx_t'({28'd0, rd_cl} * N_CORES + {28'd0, rd_core});
    assign access    = apb.psel && apb.penable;
    assign pop_fire  = access && !apb.pwrite && rd_hit && !is_status && !empty[rd_idx];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned f = 0; f < N_FIFOS; f++) begin
                wr_ptr[f] <= '0;
                rd_ptr[f] <= '0;
                count[f]  <= '0;
            end
        end else begin
            for (int unsigned f = 0; f < N_FIFOS; f++) begin
                logic push_f;
                logic pop_f;
                push_f = push_fire && (in_idx == idx_t'(f));
                pop_f  = pop_fire && (rd_idx == idx_t'(f));
                if (push_f) wr_ptr[f] <= wr_ptr[f] + ptr_t'(1);
                if (pop_f)  rd_ptr[f] <= rd_ptr[f] + ptr_t'(1);
                unique case ({push_f, pop_f})
                    2'b10:   count[f] <= count[f] + cnt_t'(1);
                    2'b01:   count[f] <= count[f] - cnt_t'(1);
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the byte storage has no reset; emptiness is tracked by the reset counters alone.
    always_ff @(posedge clk_i) begin
        if (push_fire) mem[in_idx][wr_ptr[in_idx]] <= in_data_i;
    end

    assign apb.pready = 1'b1;

    // NOTE: every output gets a default at the top of the block so no path infers a latch.
    always_comb begin
        apb.prdata  = '0;
        apb.pslverr = apb.psel && (apb.pwrite || !rd_hit);
        if (rd_hit && !apb.pwrite) begin
            if (is_status) begin
                apb.prdata[15:0] = 16'(count[rd_idx]);
`ifdef APB_STDIN_DROP_EN
                apb.prdata[31:16] = drop_cnt[rd_idx];
`endif
            end else if (empty[rd_idx]) begin
                apb.prdata = '1;
            end else begin
                apb.prdata[7:0] = mem[rd_idx][rd_ptr[rd_idx]];
            end
        end
    end

endmodule

// File: tb/tb_apb_stdin.sv
// Scoreboard bench for apb_stdin: per-queue byte model plus an expected-response queue.
// Covers both builds; the drop-counter checks are active when APB_STDIN_DROP_EN is defined.
module tb_apb_stdin;

    localparam int N_CL  = 1;
    localparam int N_CO  = 8;
    localparam int DEPTH = 16;
    localparam int N_F   = N_CL * N_CO;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_cl;
    logic [3:0] in_core;
    logic [7:0] in_data;

    always #5 clk_i = ~clk_i;

    APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

    apb_stdin #(
        .N_CLUSTERS(N_CL),
        .N_CORES   (N_CO),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_cl_i   (in_cl),
        .in_core_i (in_core),
        .in_data_i (in_data),
        .apb       (apb)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference model: one byte queue and one drop counter per (cluster, core).
    logic [7:0]  mdl   [N_F][$];
    logic [15:0] mdrop [N_F];

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];

    function automatic int fidx(input logic [3:0] cl, input logic [3:0] co);
        if (int'(cl) >= N_CL || int'(co) >= N_CO) return -1;
        return int'(cl) * N_CO + int'(co);
    endfunction

    function automatic logic exp_ready(input logic [3:0] cl, input logic [3:0] co);
        int f;
        f = fidx(cl, co);
        if (f < 0) return 1'b1;
`ifdef APB_STDIN_DROP_EN
        return 1'b1;
`else
        return mdl[f].size() < DEPTH;
`endif
    endfunction

    function automatic void model_push(input logic [3:0] cl, input logic [3:0] co, input logic [7:0] d);
        int f;
        f = fidx(cl, co);
        if (f < 0) return;
        if (mdl[f].size() < DEPTH) mdl[f].push_back(d);
        else if (mdrop[f] != 16'hFFFF) mdrop[f] = mdrop[f] + 16'd1;
    endfunction

    function automatic exp_t exp_read(input logic wr, input logic [31:0] addr, input string tag);
        exp_t e;
        int   f;
        f          = fidx(addr[10:7], addr[6:3]);
        e.tag      = tag;
        e.err      = wr || (f < 0);
        e.chk_data = !e.err;
        e.data     = '0;
        if (f >= 0) begin
            if (addr[2]) e.data = {mdrop[f], 16'(mdl[f].size())};
            else if (mdl[f].size() == 0) e.data = 32'hFFFF_FFFF;
            else e.data = {24'd0, mdl[f][0]};
        end
        return e;
    endfunction

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic host_push(input logic [3:0] cl, input logic [3:0] co, input logic [7:0] d, input string tag);
        logic rdy;
        in_valid = 1'b1;
        in_cl    = cl;
        in_core  = co;
        in_data  = d;
        rdy      = exp_ready(cl, co);
        @(negedge clk_i);
        check({tag, "_rdy"}, 32'(in_ready), 32'(rdy));
        @(posedge clk_i);
        #1;
        if (rdy) model_push(cl, co, d);
        in_valid = 1'b0;
    endtask

    task automatic apb_access(input logic wr, input logic [31:0] addr, input logic do_push,
                              input logic [3:0] pcl, input logic [3:0] pco, input logic [7:0] pdat,
                              input string tag);
        exp_t e;
        logic rdy;
        logic do_pop;
        int   f;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = 32'hDEAD_BEEF;
        @(posedge clk_i);
        #1;
        apb.penable = 1'b1;
        if (do_push) begin
            in_valid = 1'b1;
            in_cl    = pcl;
            in_core  = pco;
            in_data  = pdat;
        end
        sb.push_back(exp_read(wr, addr, tag));
        rdy = exp_ready(pcl, pco);
        @(negedge clk_i);
        e = sb.pop_front();
        check({e.tag, "_err"}, 32'(apb.pslverr), 32'(e.err));
        check({e.tag, "_pready"}, 32'(apb.pready), 32'd1);
        if (e.chk_data) check({e.tag, "_data"}, apb.prdata, e.data);
        if (do_push) check({tag, "_rdy"}, 32'(in_ready), 32'(rdy));
        @(posedge clk_i);
        #1;
        f      = fidx(addr[10:7], addr[6:3]);
        do_pop = !wr && (f >= 0) && !addr[2] && (mdl[f].size() > 0);
        if (do_push && rdy) model_push(pcl, pco, pdat);
        if (do_pop) void'(mdl[f].pop_front());
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        in_valid    = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, input string tag);
        apb_access(1'b0, addr, 1'b0, 4'd0, 4'd0, 8'd0, tag);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_cl    = 4'd0;
        in_core  = 4'd0;
        rst_ni   = 1'b0;
        @(negedge clk_i);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < N_F; i++) begin
            mdl[i].delete();
            mdrop[i] = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        in_valid    = 1'b0;
        in_cl       = 4'd0;
        in_core     = 4'd0;
        in_data     = 8'd0;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;
        @(posedge clk_i);
        #1;
        do_reset();

        for (int c = 0; c < N_CO; c++) apb_read(32'(c * 8 + 4), "rst_status");
        apb_read(32'h000, "rst_data_empty");

        // Three characters in order, then empty and zero occupancy.
        host_push(4'd0, 4'd1, 8'h41, "abc_push");
        host_push(4'd0, 4'd1, 8'h42, "abc_push");
        host_push(4'd0, 4'd1, 8'h43, "abc_push");
        for (int i = 0; i < 4; i++) apb_read(32'h008, "abc_read");
        apb_read(32'h00C, "abc_status");

        // Fill to depth, overflow attempt, one pop, then ordering across wrap.
        for (int i = 0; i < DEPTH; i++) host_push(4'd0, 4'd0, 8'h30 + 8'(i), "fill_push");
        host_push(4'd0, 4'd0, 8'hEE, "full_push");
        apb_read(32'h000, "full_pop");
        in_cl   = 4'd0;
        in_core = 4'd0;
        @(negedge clk_i);
        check("ready_after_pop", 32'(in_ready), 32'd1);
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 5; i++) host_push(4'd0, 4'd0, 8'h60 + 8'(i), "wrap_push");
        apb_read(32'h004, "wrap_status");
        for (int i = 0; i < DEPTH + 1; i++) apb_read(32'h000, "wrap_read");

        // Same-cycle push and pop.
        for (int i = 0; i < 3; i++) host_push(4'd0, 4'd2, 8'h70 + 8'(i), "pp_push");
        apb_access(1'b0, 32'h010, 1'b1, 4'd0, 4'd2, 8'h7A, "pp_same");
        apb_read(32'h014, "pp_status");
        apb_access(1'b0, 32'h018, 1'b1, 4'd0, 4'd3, 8'h55, "pp_empty");
        apb_read(32'h01C, "pp_empty_status");
        apb_read(32'h018, "pp_empty_data");

        // Error responses and out-of-range host indices.
        host_push(4'd0, 4'd0, 8'h5A, "err_push");
        apb_access(1'b1, 32'h000, 1'b0, 4'd0, 4'd0, 8'd0, "err_write");
        apb_read(32'h004, "err_status");
        apb_read(32'h080, "err_cluster");
        host_push(4'd0, 4'd15, 8'h11, "oor_core");
        host_push(4'd1, 4'd0, 8'h22, "oor_cluster");
        for (int c = 0; c < N_CO; c++) apb_read(32'(c * 8 + 4), "oor_status");

        // Random mixed traffic concentrated on a few queues to hit full/empty often.
        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [3:0]  co;
            logic [3:0]  pco;
            op  = $urandom_range(0, 99);
            co  = 4'($urandom_range(0, 2));
            pco = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 2));
            if (op < 50) host_push(4'd0, pco, 8'($urandom), "rnd_push");
            else if (op < 70) apb_read({25'd0, co, 3'b000}, "rnd_read");
            else if (op < 85) apb_access(1'b0, {25'd0, co, 3'b000}, 1'b1, 4'd0, pco, 8'($urandom), "rnd_pp");
            else apb_read({25'd0, co, 3'b100}, "rnd_status");
        end
        for (int c = 0; c < 3; c++) apb_read(32'(c * 8 + 4), "rnd_final_status");

        // Reset in the middle of a stream discards queued bytes.
        for (int i = 0; i < 5; i++) host_push(4'd0, 4'd5, 8'h90 + 8'(i), "mid_push");
        do_reset();
        apb_read(32'h02C, "mid_status");
        apb_read(32'h028, "mid_data");

`ifdef APB_STDIN_DROP_EN
        for (int i = 0; i < 20; i++) host_push(4'd0, 4'd4, 8'hA0 + 8'(i), "drop_push");
        apb_read(32'h024, "drop_status");
        do_reset();
        apb_read(32'h024, "drop_status_rst");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_stdin.md
APB_STDIN -- requirements
Module: apb_stdin

Interface
REQ-001 SHALL have parameters: N_CLUSTERS, default 1, number of clusters served (max 16).
REQ-002 SHALL have parameter N_CORES, default 8, cores per cluster (max 16).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, bytes per core queue (power of two, 2..256).
REQ-006 SHALL have port clk_i, input, 1 bit, clock, all logic on rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port in_valid_i, input, 1 bit, host byte valid.
REQ-009 SHALL have port in_ready_o, output, 1 bit, host byte accepted when high with in_valid_i.
REQ-010 SHALL have ports in_cl_i and in_core_i, input, 4 bits each, destination cluster/core.
REQ-011 SHALL have port in_data_i, input, 8 bits, character.
REQ-012 SHALL have port apb, APB_BUS.Slave, core-side register access.

Function
REQ-013 SHALL keep one independent FIFO_DEPTH-byte FIFO per (cluster, core) pair.
REQ-014 SHALL decode: cluster = paddr[10:7], core = paddr[6:3], paddr[2] = 0 DATA register, 1 STATUS register.
REQ-015 SHALL push in_data_i into the addressed FIFO on in_valid_i && in_ready_o.
REQ-016 SHALL drive in_ready_o = 1 for out-of-range indices (byte dropped), otherwise !full of target FIFO; in_ready_o SHALL depend only on registered state and in_* inputs.
REQ-017 SHALL drive pready = 1 always (zero wait states); access phase = psel && penable.
REQ-018 DATA read SHALL return {24'h0, head byte} and pop one entry in that cycle; if empty, SHALL return 32'hFFFF_FFFF and not pop.
REQ-019 STATUS read SHALL return [15:0] occupancy, [31:16] drop count (REQ-027) or 0; no side effects.
REQ-020 prdata SHALL be combinational from current FIFO state; pslverr = 1 on any write or out-of-range index, else 0.
REQ-021 APB writes SHALL have no effect on state.
REQ-022 A byte pushed in cycle N SHALL be readable via DATA in cycle N+1, not N.
REQ-023 Simultaneous push and pop on the same FIFO SHALL both take effect; occupancy unchanged; a full FIFO stays full-gated (in_ready_o low) that cycle.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL range 0..FIFO_DEPTH exactly.

Reset
REQ-025 On rst_ni low, all FIFOs SHALL become empty, drop counters 0, in_ready_o reflects empty FIFOs (1 while held in reset for valid indices); reset mid-transfer discards queued bytes.

Configuration
REQ-026 Macro APB_STDIN_DROP_EN SHALL select overflow behaviour.
REQ-027 With APB_STDIN_DROP_EN defined: in_ready_o SHALL be constant 1; bytes to a full FIFO are discarded and increment that core's 16-bit drop counter, saturating at 16'hFFFF.
REQ-028 Without APB_STDIN_DROP_EN: backpressure per REQ-016; no drop counters implemented; STATUS[31:16] = 0.

Verification
REQ-029 Push 'A','B','C' to cl0/core1, then three DATA reads at 0x008 -> 0x41, 0x42, 0x43; fourth read -> 0xFFFF_FFFF, STATUS -> 0.
REQ-030 Push 16 bytes to cl0/core0 (depth 16) -> in_ready_o low on 17th; one DATA read -> in_ready_o high next cycle; FIFO order preserved across pointer wrap.
REQ-031 Push and DATA read same cycle on FIFO with 3 entries -> occupancy stays 3; push to empty FIFO with same-cycle read -> read returns 0xFFFF_FFFF.
REQ-032 APB write to 0x000 and read of cluster index >= N_CLUSTERS -> pslverr = 1, no state change; host push to core 15 with N_CORES 8 -> accepted and dropped.
REQ-033 With APB_STDIN_DROP_EN, push 20 bytes to full-capable depth-16 FIFO -> STATUS = 0x0004_0010; assert rst_ni mid-stream -> STATUS = 0 after reset.
